// File: rtl/risc_pkg.sv
// Shared definitions for the memory arbiter: arbiter state encoding, owner codes
// and the default bus widths.
package risc_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 16;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_CPU  = 2'b01;
    localparam logic [1:0] OWNER_DMA  = 2'b10;

    // State values double as the owner code driven on the owner port.
    typedef enum logic [1:0] {
        IDLE    = OWNER_NONE,
        GNT_CPU = OWNER_CPU,
        GNT_DMA = OWNER_DMA
    } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter for a single synchronous memory with bounded bursts,
// round-robin tie breaking and read-data steering back to the issuing requester.
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dout,
    output logic          mem_we,
    input  logic [DW-1:0] mem_din,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    state_t        state, state_nxt;
    logic [CW-1:0] burst_cnt, burst_cnt_nxt;
    logic          last_dma, last_dma_nxt;
    logic          cpu_rd_pend, dma_rd_pend;
    logic          cpu_go, dma_go, burst_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_dma    <= 1'b1;
            cpu_rd_pend <= 1'b0;
            dma_rd_pend <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_cnt_nxt;
            last_dma    <= last_dma_nxt;
            cpu_rd_pend <= cpu_ack & ~cpu_we;
            dma_rd_pend <= dma_ack & ~dma_we;
        end
    end

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        last_dma_nxt  = last_dma;
        cpu_go        = (state == GNT_CPU) && cpu_req;
        dma_go        = (state == GNT_DMA) && dma_req;
        // Current ack is the last one allowed while the other side waits.
        burst_done    = (burst_cnt >= BURST_MAX - 1'b1);

        unique case (state)
            IDLE: begin
                if (cpu_req && dma_req) state_nxt = last_dma ? GNT_CPU : GNT_DMA;
                else if (cpu_req)       state_nxt = GNT_CPU;
                else if (dma_req)       state_nxt = GNT_DMA;
            end
            GNT_CPU: begin
                if (!cpu_req)                  state_nxt = dma_req ? GNT_DMA : IDLE;
                else if (dma_req && burst_done) state_nxt = GNT_DMA;
            end
            GNT_DMA: begin
                if (!dma_req)                  state_nxt = cpu_req ? GNT_CPU : IDLE;
                else if (cpu_req && burst_done) state_nxt = GNT_CPU;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) begin
            burst_cnt_nxt = '0;
            if (state_nxt == GNT_CPU) last_dma_nxt = 1'b0;
            if (state_nxt == GNT_DMA) last_dma_nxt = 1'b1;
        end else if ((cpu_go || dma_go) && burst_cnt != BURST_MAX) begin
            burst_cnt_nxt = burst_cnt + 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held, before the state register settles.
    always_comb begin
        cpu_ack    = reset & cpu_go;
        dma_ack    = reset & dma_go;
        cpu_wait   = cpu_req & ~cpu_ack;
        mem_we     = (cpu_ack & cpu_we) | (dma_ack & dma_we);
        owner      = reset ? state : OWNER_NONE;
        cpu_rvalid = reset & cpu_rd_pend;
        dma_rvalid = reset & dma_rd_pend;
        cpu_rdata  = cpu_rvalid ? mem_din : '0;
        dma_rdata  = dma_rvalid ? mem_din : '0;
        mem_addr   = '0;
        mem_dout   = '0;
        if (reset && state == GNT_CPU) begin
            mem_addr = cpu_addr;
            mem_dout = cpu_wdata;
        end else if (reset && state == GNT_DMA) begin
            mem_addr = dma_addr;
            mem_dout = dma_wdata;
        end
    end

    ack_exclusive: assert property (@(posedge clk) !(cpu_ack && dma_ack))
        else $fatal(1, "mem_arbiter: cpu_ack and dma_ack asserted together");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-scenario tasks plus a read-data scoreboard
// that pairs each expected read return with the rvalid pulse it must produce.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack, cpu_wait, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_ack, dma_rvalid;
    logic [15:0] dma_rdata;
    logic [15:0] mem_addr, mem_dout, mem_din = 16'hA5A5;
    logic        mem_we;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        is_dma;
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    rd_exp_t mon_e;

    mem_arbiter #(.DW(16), .AW(16), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we), .mem_din(mem_din),
        .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every rvalid must match the oldest expected read, on its due cycle.
    always @(negedge clk) begin
        if (cpu_rvalid || dma_rvalid) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected cyc=%0d cpu_rvalid=%b dma_rvalid=%b required none",
                         cyc, cpu_rvalid, dma_rvalid);
            end else begin
                mon_e = rd_q.pop_front();
                if ({cpu_rvalid, dma_rvalid} !== (mon_e.is_dma ? 2'b01 : 2'b10) ||
                    (mon_e.is_dma ? dma_rdata : cpu_rdata) !== mon_e.data || cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL rvalid_match cyc=%0d cpu/dma_rvalid=%b%b rdata=%h/%h required dma=%b data=%h cyc=%0d",
                             cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata,
                             mon_e.is_dma, mon_e.data, mon_e.due);
                end
            end
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_missing cyc=%0d required dma=%b data=%h", cyc, rd_q[0].is_dma, rd_q[0].data);
            void'(rd_q.pop_front());
        end
        n_tests++;
        if ((!cpu_rvalid && cpu_rdata !== 16'h0) || (!dma_rvalid && dma_rdata !== 16'h0)) begin
            n_fail++;
            $display("FAIL rdata_idle_zero cyc=%0d cpu_rdata=%h dma_rdata=%h required 0000", cyc, cpu_rdata, dma_rdata);
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        next_cycle();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_we cyc=%0d mem_we=%b required 0", cyc, mem_we);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (owner !== 2'b00 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL drain_idle cyc=%0d owner=%b mem_addr=%h required 00/0000", cyc, owner, mem_addr);
        end
    endtask

    task automatic test_reset;
        // {owner, cpu_ack, dma_ack, mem_we, cpu_wait, cpu_rvalid, dma_rvalid}
        reset   = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) begin
                reset     = 1'b1;
                dma_req   = 1'b1;
                dma_we    = 1'b1;
                cpu_addr  = 16'h0040;
                cpu_wdata = 16'h1111;
                dma_addr  = 16'h0080;
            end
            @(negedge clk);
            n_tests++;
            if ({owner, cpu_ack, dma_ack, mem_we, cpu_wait, cpu_rvalid, dma_rvalid} !== 8'b0000_0100 ||
                mem_addr !== 16'h0 || mem_dout !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_outputs step=%0d flags=%b addr=%h dout=%h required 00000100/0000/0000",
                         i, {owner, cpu_ack, dma_ack, mem_we, cpu_wait, cpu_rvalid, dma_rvalid}, mem_addr, mem_dout);
            end
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({owner, cpu_ack, dma_ack, mem_we, cpu_wait} !== 6'b01_1010 ||
            mem_addr !== 16'h0040 || mem_dout !== 16'h1111) begin
            n_fail++;
            $display("FAIL first_tie flags=%b addr=%h dout=%h required 011010/0040/1111",
                     {owner, cpu_ack, dma_ack, mem_we, cpu_wait}, mem_addr, mem_dout);
        end
        drain();
    endtask

    task automatic test_read_latency;
        next_cycle();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        @(negedge clk);
        n_tests++;
        if (cpu_ack !== 1'b0 || cpu_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_no_ack cpu_ack=%b cpu_wait=%b required 0/1", cpu_ack, cpu_wait);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (cpu_ack !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0 || owner !== 2'b01) begin
            n_fail++;
            $display("FAIL read_issue ack=%b addr=%h we=%b owner=%b required 1/0010/0/01",
                     cpu_ack, mem_addr, mem_we, owner);
        end
        rd_q.push_back('{is_dma: 1'b0, data: 16'hBEEF, due: cyc + 1});
        next_cycle();
        cpu_req = 1'b0;
        mem_din = 16'hBEEF;
        @(negedge clk);
        n_tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF || dma_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_return cpu_rvalid=%b cpu_rdata=%h dma_rvalid=%b required 1/beef/0",
                     cpu_rvalid, cpu_rdata, dma_rvalid);
        end
        drain();
    endtask

    task automatic test_burst_limit;
        logic exp_cpu, prev_cpu;
        next_cycle();
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 16'h0300;
        @(negedge clk);
        prev_cpu = 1'b0;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            if (i > 0) begin
                if (prev_cpu) cpu_addr = cpu_addr + 16'd1;
                else          dma_addr = dma_addr + 16'd1;
            end
            if (i == 0) begin
                dma_req  = 1'b1;
                dma_we   = 1'b1;
                dma_addr = 16'h0400;
            end
            exp_cpu = ((i / 4) % 2 == 0);
            @(negedge clk);
            n_tests++;
            if ({cpu_ack, dma_ack} !== (exp_cpu ? 2'b10 : 2'b01) || owner !== (exp_cpu ? 2'b01 : 2'b10) ||
                mem_we !== 1'b1 || mem_addr !== (exp_cpu ? cpu_addr : dma_addr)) begin
                n_fail++;
                $display("FAIL burst_alternate i=%0d acks=%b owner=%b we=%b addr=%h required cpu_first_half=%b addr=%h",
                         i, {cpu_ack, dma_ack}, owner, mem_we, mem_addr, exp_cpu, exp_cpu ? cpu_addr : dma_addr);
            end
            prev_cpu = exp_cpu;
        end
        drain();
    endtask

    task automatic test_uncontested_burst;
        int pulses;
        logic [2:0] exp_cnt;
        pulses = 0;
        next_cycle();
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'h0100;
        dma_wdata = 16'hD000;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            dma_addr  = 16'h0100 + 16'(i);
            dma_wdata = 16'hD000 + 16'(i);
            exp_cnt   = (i < 4) ? 3'(i) : 3'd4;
            @(negedge clk);
            if (mem_we === 1'b1) pulses++;
            n_tests++;
            if (dma_ack !== 1'b1 || owner !== 2'b10 || mem_addr !== dma_addr ||
                mem_dout !== dma_wdata || dut.burst_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL uncontested i=%0d ack=%b owner=%b addr=%h dout=%h cnt=%0d required 1/10/%h/%h/%0d",
                         i, dma_ack, owner, mem_addr, mem_dout, dut.burst_cnt, dma_addr, dma_wdata, exp_cnt);
            end
        end
        n_tests++;
        if (pulses != 10) begin
            n_fail++;
            $display("FAIL uncontested_pulses got=%0d required 10", pulses);
        end
        drain();
    endtask

    task automatic test_handover_read;
        next_cycle();
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 16'h0500;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            dma_req  = 1'b1;
            dma_we   = 1'b1;
            dma_addr = 16'h0600;
            cpu_addr = (i == 3) ? 16'h0020 : 16'h0500 + 16'(i);
            cpu_we   = (i != 3);
            @(negedge clk);
            n_tests++;
            if (cpu_ack !== 1'b1 || owner !== 2'b01 || mem_we !== cpu_we) begin
                n_fail++;
                $display("FAIL handover_cpu i=%0d ack=%b owner=%b we=%b required 1/01/%b",
                         i, cpu_ack, owner, mem_we, cpu_we);
            end
        end
        rd_q.push_back('{is_dma: 1'b0, data: 16'h1234, due: cyc + 1});
        next_cycle();
        cpu_req = 1'b0;
        mem_din = 16'h1234;
        @(negedge clk);
        n_tests++;
        if (owner !== 2'b10 || dma_ack !== 1'b1 || cpu_rvalid !== 1'b1 ||
            dma_rvalid !== 1'b0 || cpu_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL handover_steer owner=%b dma_ack=%b rvalid=%b%b cpu_rdata=%h required 10/1/10/1234",
                     owner, dma_ack, cpu_rvalid, dma_rvalid, cpu_rdata);
        end
        drain();
    endtask

    task automatic test_reset_mid_burst;
        next_cycle();
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 16'h0200;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            dma_addr = 16'h0200 + 16'(i);
            mem_din  = 16'h5A00 + 16'(i);
            @(negedge clk);
            n_tests++;
            if (dma_ack !== 1'b1 || owner !== 2'b10) begin
                n_fail++;
                $display("FAIL midburst_access i=%0d ack=%b owner=%b required 1/10", i, dma_ack, owner);
            end
            if (i == 0) rd_q.push_back('{is_dma: 1'b1, data: 16'h5A01, due: cyc + 1});
        end
        next_cycle();
        dma_addr = 16'h0202;
        mem_din  = 16'h5A02;
        reset    = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dma_rvalid !== 1'b0 || owner !== 2'b00 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_during rvalid=%b owner=%b we=%b required 0/00/0", dma_rvalid, owner, mem_we);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (owner !== 2'b00 || dma_ack !== 1'b0 || dma_rvalid !== 1'b0 ||
            mem_we !== 1'b0 || dut.burst_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_after owner=%b ack=%b rvalid=%b we=%b cnt=%0d required 00/0/0/0/0",
                     owner, dma_ack, dma_rvalid, mem_we, dut.burst_cnt);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (owner !== 2'b10 || dma_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL regrant owner=%b ack=%b required 10/1", owner, dma_ack);
        end
        rd_q.push_back('{is_dma: 1'b1, data: 16'h5A03, due: cyc + 1});
        next_cycle();
        dma_req = 1'b0;
        mem_din = 16'h5A03;
        @(negedge clk);
        drain();
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_burst_limit();
        test_uncontested_burst();
        test_handover_read();
        test_reset_mid_burst();
        repeat (2) next_cycle();
        n_tests++;
        if (rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty left=%0d required 0", rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
